// File: rtl/alu_seq_core.sv
// Registered, start/busy/done sequenced 8051-style ALU with iterative shift-add MUL and restoring DIV.
// Define ALU_SEQ_FAST_MULDIV_EN to compute MUL/DIV in a single cycle with combinational operators.
module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int OPC_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [OPC_W-1:0] alu_opcode,
  input  logic [WIDTH-1:0] op_in_1,
  input  logic [WIDTH-1:0] op_in_2,
  input  logic             carry_in,
  input  logic             aux_carry_in,
  input  logic             bit_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] op_out_1,
  output logic [WIDTH-1:0] op_out_2,
  output logic             carry_out,
  output logic             aux_carry_out,
  output logic             overflow_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [OPC_W-1:0] ALU_ADD  = OPC_W'(1);
  localparam logic [OPC_W-1:0] ALU_ADDC = OPC_W'(2);
  localparam logic [OPC_W-1:0] ALU_SUBB = OPC_W'(3);
  localparam logic [OPC_W-1:0] ALU_INC  = OPC_W'(4);
  localparam logic [OPC_W-1:0] ALU_DEC  = OPC_W'(5);
  localparam logic [OPC_W-1:0] ALU_MUL  = OPC_W'(6);
  localparam logic [OPC_W-1:0] ALU_DIV  = OPC_W'(7);
  localparam logic [OPC_W-1:0] ALU_DA   = OPC_W'(8);
  localparam logic [OPC_W-1:0] ALU_CPL  = OPC_W'(9);
  localparam logic [OPC_W-1:0] ALU_SWAP = OPC_W'(10);
  localparam logic [OPC_W-1:0] ALU_RR   = OPC_W'(11);
  localparam logic [OPC_W-1:0] ALU_RL   = OPC_W'(12);
  localparam logic [OPC_W-1:0] ALU_RRC  = OPC_W'(13);
  localparam logic [OPC_W-1:0] ALU_RLC  = OPC_W'(14);
  localparam logic [OPC_W-1:0] ALU_ANL  = OPC_W'(15);
  localparam logic [OPC_W-1:0] ALU_ORL  = OPC_W'(16);
  localparam logic [OPC_W-1:0] ALU_XRL  = OPC_W'(17);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_r, state_nxt_s;

  logic             accept_s;
  logic             iter_req_s;
  logic [OPC_W-1:0] opc_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic             cin_r, acin_r, bit_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] hi_nxt_s, lo_nxt_s;

  logic             add_cin_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [2*WIDTH-1:0] inc_s;
  logic [8:0]       da_t1_s;
  logic             da_fix_s;
  logic [7:0]       da_t2_s;

  logic [WIDTH-1:0] mul_hi_s, mul_lo_s, div_q_s, div_r_s;

  logic [WIDTH-1:0] res1_s, res2_s;
  logic             cy_s, ac_s, ov_s;

`ifdef ALU_SEQ_FAST_MULDIV_EN
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   divisor_s;

  assign iter_req_s = 1'b0;
  assign prod_s     = a_r * b_r;
  // Zero divisor is substituted only to keep the operator defined; DIV by zero takes its own result path.
  assign divisor_s  = (b_r == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_r;
  assign mul_hi_s   = prod_s[2*WIDTH-1:WIDTH];
  assign mul_lo_s   = prod_s[WIDTH-1:0];
  assign div_q_s    = a_r / divisor_s;
  assign div_r_s    = a_r % divisor_s;
`else
  assign iter_req_s = (alu_opcode == ALU_MUL) ||
                      ((alu_opcode == ALU_DIV) && (op_in_2 != {WIDTH{1'b0}}));
  assign mul_hi_s   = hi_r;
  assign mul_lo_s   = lo_r;
  assign div_q_s    = lo_r;
  assign div_r_s    = hi_r;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a request is taken in IDLE and in the DONE cycle
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = iter_req_s ? ITER : EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = DONE;
      ITER: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = ITER;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // One MUL (shift-add) or DIV (restoring) step; hi holds product-high / remainder, lo holds multiplier / quotient
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + ({1'b0, a_r} & {(WIDTH+1){lo_r[0]}});
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, b_r});
    if (opc_r == ALU_MUL) begin
      hi_nxt_s = mul_sum_s[WIDTH:1];
      lo_nxt_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end else if (div_ge_s) begin
      hi_nxt_s = div_shift_s[WIDTH-1:0] - b_r;
      lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt_s = div_shift_s[WIDTH-1:0];
      lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Arithmetic helpers; nibble and MSB carries are recovered as a^b^sum at the bit above
  always_comb begin
    add_cin_s = (opc_r == ALU_ADDC) & cin_r;
    add_s     = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, add_cin_s};
    sub_s     = {1'b0, a_r} - {1'b0, b_r} - {{WIDTH{1'b0}}, cin_r};
    inc_s     = {b_r, a_r} + {{(2*WIDTH-1){1'b0}}, 1'b1};
    if (acin_r || (a_r[3:0] > 4'd9)) begin
      da_t1_s = {1'b0, a_r[7:0]} + 9'h006;
    end else begin
      da_t1_s = {1'b0, a_r[7:0]};
    end
    da_fix_s = cin_r || (da_t1_s[7:4] > 4'd9) || da_t1_s[8];
    if (da_fix_s) begin
      da_t2_s = da_t1_s[7:0] + 8'h60;
    end else begin
      da_t2_s = da_t1_s[7:0];
    end
  end

  // Result select; anything an opcode does not define keeps its current output value
  always_comb begin
    res1_s = op_out_1;
    res2_s = op_out_2;
    cy_s   = carry_out;
    ac_s   = aux_carry_out;
    ov_s   = overflow_out;
    case (opc_r)
      ALU_ADD, ALU_ADDC: begin
        res1_s = add_s[WIDTH-1:0];
        cy_s   = add_s[WIDTH];
        ac_s   = a_r[4] ^ b_r[4] ^ add_s[4];
        ov_s   = (a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ add_s[WIDTH-1]) ^ add_s[WIDTH];
      end
      ALU_SUBB: begin
        res1_s = sub_s[WIDTH-1:0];
        cy_s   = sub_s[WIDTH];
        ac_s   = a_r[4] ^ b_r[4] ^ sub_s[4];
        ov_s   = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (sub_s[WIDTH-1] ^ a_r[WIDTH-1]);
      end
      ALU_INC: {res2_s, res1_s} = inc_s;
      ALU_DEC: res1_s = a_r - {{(WIDTH-1){1'b0}}, 1'b1};
      ALU_MUL: begin
        res1_s = mul_lo_s;
        res2_s = mul_hi_s;
        cy_s   = 1'b0;
        ov_s   = |mul_hi_s;
      end
      ALU_DIV: begin
        cy_s = 1'b0;
        if (b_r == {WIDTH{1'b0}}) begin
          res1_s = {WIDTH{1'b1}};
          res2_s = a_r;
          ov_s   = 1'b1;
        end else begin
          res1_s = div_q_s;
          res2_s = div_r_s;
          ov_s   = 1'b0;
        end
      end
      ALU_DA: begin
        res1_s      = a_r;
        res1_s[7:0] = da_t2_s;
        if (da_fix_s) begin
          cy_s = 1'b1;
        end else begin
          cy_s = carry_out;
        end
      end
      ALU_CPL:  res1_s = ~a_r;
      ALU_SWAP: res1_s = {a_r[WIDTH/2-1:0], a_r[WIDTH-1:WIDTH/2]};
      ALU_RR:   res1_s = {a_r[0], a_r[WIDTH-1:1]};
      ALU_RL:   res1_s = {a_r[WIDTH-2:0], a_r[WIDTH-1]};
      ALU_RRC: begin
        res1_s = {cin_r, a_r[WIDTH-1:1]};
        cy_s   = a_r[0];
      end
      ALU_RLC: begin
        res1_s = {a_r[WIDTH-2:0], cin_r};
        cy_s   = a_r[WIDTH-1];
      end
      ALU_ANL: begin
        res1_s = a_r & b_r;
        cy_s   = cin_r & bit_r;
      end
      ALU_ORL: begin
        res1_s = a_r | b_r;
        cy_s   = cin_r | bit_r;
      end
      ALU_XRL: res1_s = a_r ^ b_r;
      default: res1_s = op_out_1;
    endcase
  end

  // Request capture and iteration registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opc_r  <= {OPC_W{1'b0}};
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      cin_r  <= 1'b0;
      acin_r <= 1'b0;
      bit_r  <= 1'b0;
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      opc_r  <= alu_opcode;
      a_r    <= op_in_1;
      b_r    <= op_in_2;
      cin_r  <= carry_in;
      acin_r <= aux_carry_in;
      bit_r  <= bit_in;
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= (alu_opcode == ALU_MUL) ? op_in_2 : op_in_1;
      cnt_r  <= {CNT_W{1'b0}};
    end else if (state_r == ITER) begin
      hi_r   <= hi_nxt_s;
      lo_r   <= lo_nxt_s;
      cnt_r  <= cnt_r + CNT_W'(1);
    end
  end

  // Registered results and handshake outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      op_out_1      <= {WIDTH{1'b0}};
      op_out_2      <= {WIDTH{1'b0}};
      carry_out     <= 1'b0;
      aux_carry_out <= 1'b0;
      overflow_out  <= 1'b0;
    end else begin
      busy <= (state_nxt_s == EXEC) || (state_nxt_s == ITER);
      done <= (state_nxt_s == DONE);
      if (state_r == EXEC) begin
        op_out_1      <= res1_s;
        op_out_2      <= res2_s;
        carry_out     <= cy_s;
        aux_carry_out <= ac_s;
        overflow_out  <= ov_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Table-driven, scoreboard-checked bench for alu_seq_core at WIDTH=8.
module tb_alu_seq_core;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_ADDC = 5'd2;
  localparam logic [4:0] OP_SUBB = 5'd3;
  localparam logic [4:0] OP_INC  = 5'd4;
  localparam logic [4:0] OP_DEC  = 5'd5;
  localparam logic [4:0] OP_MUL  = 5'd6;
  localparam logic [4:0] OP_DIV  = 5'd7;
  localparam logic [4:0] OP_DA   = 5'd8;
  localparam logic [4:0] OP_CPL  = 5'd9;
  localparam logic [4:0] OP_SWAP = 5'd10;
  localparam logic [4:0] OP_RR   = 5'd11;
  localparam logic [4:0] OP_RL   = 5'd12;
  localparam logic [4:0] OP_RRC  = 5'd13;
  localparam logic [4:0] OP_RLC  = 5'd14;
  localparam logic [4:0] OP_ANL  = 5'd15;
  localparam logic [4:0] OP_ORL  = 5'd16;
  localparam logic [4:0] OP_XRL  = 5'd17;
  localparam logic [4:0] OP_BAD  = 5'd31;

`ifdef ALU_SEQ_FAST_MULDIV_EN
  localparam int MD_LAT = 1;
`else
  localparam int MD_LAT = 9;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] alu_opcode;
  logic [7:0] op_in_1, op_in_2;
  logic       carry_in, aux_carry_in, bit_in;
  logic       busy, done;
  logic [7:0] op_out_1, op_out_2;
  logic       carry_out, aux_carry_out, overflow_out;

  alu_seq_core #(.WIDTH(8), .OPC_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .alu_opcode(alu_opcode),
    .op_in_1(op_in_1), .op_in_2(op_in_2), .carry_in(carry_in),
    .aux_carry_in(aux_carry_in), .bit_in(bit_in), .busy(busy), .done(done),
    .op_out_1(op_out_1), .op_out_2(op_out_2), .carry_out(carry_out),
    .aux_carry_out(aux_carry_out), .overflow_out(overflow_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] opc;
    logic [7:0] a, b;
    logic       cin, acin, bitv;
    logic [7:0] e1, e2;
    logic       ec, eac, eov;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] e1, e2;
    logic       ec, eac, eov;
    int         lat;
  } exp_t;

  vec_t vecs [0:23];
  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic finish_op(input int cyc0, input string name);
    int   cyc;
    exp_t e;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    e = sb.pop_front();
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    if (done === 1'b1) begin
      chk({name, "_lat"}, cyc - 1, e.lat);
      chk({name, "_out1"}, {24'd0, op_out_1}, {24'd0, e.e1});
      chk({name, "_out2"}, {24'd0, op_out_2}, {24'd0, e.e2});
      chk({name, "_cy"}, {31'd0, carry_out}, {31'd0, e.ec});
      chk({name, "_ac"}, {31'd0, aux_carry_out}, {31'd0, e.eac});
      chk({name, "_ov"}, {31'd0, overflow_out}, {31'd0, e.eov});
    end
  endtask

  task automatic drive(input vec_t v);
    alu_opcode   = v.opc;
    op_in_1      = v.a;
    op_in_2      = v.b;
    carry_in     = v.cin;
    aux_carry_in = v.acin;
    bit_in       = v.bitv;
    start        = 1'b1;
    sb.push_back('{v.e1, v.e2, v.ec, v.eac, v.eov, v.lat});
  endtask

  task automatic run_op(input vec_t v, input string name);
    @(negedge clock);
    drive(v);
    @(negedge clock);
    start        = 1'b0;
    alu_opcode   = OP_BAD;
    op_in_1      = ~v.a;
    op_in_2      = ~v.b;
    carry_in     = ~v.cin;
    aux_carry_in = ~v.acin;
    bit_in       = ~v.bitv;
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    finish_op(1, name);
  endtask

  initial begin
    int   extra;
    vec_t v;

    //          opc      a      b      cin   acin  bit   e1     e2     C     AC    OV    lat
    vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 1};
    vecs[1]  = '{OP_ADDC, 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[2]  = '{OP_SUBB, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'hFE, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[3]  = '{OP_SUBB, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1, 1};
    vecs[4]  = '{OP_XRL,  8'h5A, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1, 1};
    vecs[5]  = '{OP_INC,  8'hFF, 8'h12, 1'b1, 1'b0, 1'b0, 8'h00, 8'h13, 1'b0, 1'b1, 1'b1, 1};
    vecs[6]  = '{OP_INC,  8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1};
    vecs[7]  = '{OP_DEC,  8'h00, 8'h33, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1};
    vecs[8]  = '{OP_MUL,  8'h80, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, MD_LAT};
    vecs[9]  = '{OP_MUL,  8'h0F, 8'h0E, 1'b1, 1'b0, 1'b0, 8'hD2, 8'h00, 1'b0, 1'b1, 1'b0, MD_LAT};
    vecs[10] = '{OP_DIV,  8'hFB, 8'h12, 1'b1, 1'b0, 1'b0, 8'h0D, 8'h11, 1'b0, 1'b1, 1'b0, MD_LAT};
    vecs[11] = '{OP_DIV,  8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h55, 1'b0, 1'b1, 1'b1, 1};
    vecs[12] = '{OP_DA,   8'hBD, 8'h00, 1'b0, 1'b0, 1'b0, 8'h23, 8'h55, 1'b1, 1'b1, 1'b1, 1};
    vecs[13] = '{OP_DA,   8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 8'h12, 8'h55, 1'b1, 1'b1, 1'b1, 1};
    vecs[14] = '{OP_RRC,  8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 8'h81, 8'h55, 1'b0, 1'b1, 1'b1, 1};
    vecs[15] = '{OP_RLC,  8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 8'h55, 1'b1, 1'b1, 1'b1, 1};
    vecs[16] = '{OP_RR,   8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h80, 8'h55, 1'b1, 1'b1, 1'b1, 1};
    vecs[17] = '{OP_RL,   8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 8'h55, 1'b1, 1'b1, 1'b1, 1};
    vecs[18] = '{OP_CPL,  8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h55, 1'b1, 1'b1, 1'b1, 1};
    vecs[19] = '{OP_SWAP, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h55, 1'b1, 1'b1, 1'b1, 1};
    vecs[20] = '{OP_ANL,  8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h30, 8'h55, 1'b0, 1'b1, 1'b1, 1};
    vecs[21] = '{OP_ORL,  8'hF0, 8'h0F, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h55, 1'b1, 1'b1, 1'b1, 1};
    vecs[22] = '{OP_BAD,  8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h55, 1'b1, 1'b1, 1'b1, 1};
    vecs[23] = '{OP_ADD,  8'h56, 8'h67, 1'b1, 1'b0, 1'b0, 8'hBD, 8'h55, 1'b0, 1'b0, 1'b1, 1};

    reset = 1'b0; start = 1'b0; alu_opcode = 5'd0; op_in_1 = 8'h00; op_in_2 = 8'h00;
    carry_in = 1'b0; aux_carry_in = 1'b0; bit_in = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_outs", {16'd0, op_out_1, op_out_2}, 32'd0);
    chk("rst_flags", {29'd0, carry_out, aux_carry_out, overflow_out}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 24; i++) run_op(vecs[i], $sformatf("v%0d", i));

    // MUL with a second start pulsed while it is iterating
    v = '{OP_MUL, 8'h0F, 8'h0E, 1'b1, 1'b1, 1'b0, 8'hD2, 8'h00, 1'b0, 1'b0, 1'b0, MD_LAT};
    @(negedge clock);
    drive(v);
    @(negedge clock);
    start = 1'b0;
`ifdef ALU_SEQ_FAST_MULDIV_EN
    finish_op(1, "mul_mid");
`else
    repeat (2) @(negedge clock);
    alu_opcode = OP_ADD; op_in_1 = 8'h01; op_in_2 = 8'h01; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    finish_op(4, "mul_mid");
`endif
    extra = 0;
    repeat (4) begin
      @(negedge clock);
      if (done === 1'b1) extra++;
    end
    chk("mid_no_extra_done", extra, 0);

    // start held high: accepted in IDLE and again in the DONE cycle
    @(negedge clock);
    alu_opcode = OP_ADD; op_in_1 = 8'h01; op_in_2 = 8'h01; carry_in = 1'b0; start = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 3) start = 1'b0;
      if (done === 1'b1) extra++;
    end
    chk("b2b_done_count", extra, 2);
    chk("b2b_out1", {24'd0, op_out_1}, 32'h02);
    chk("b2b_flags", {29'd0, carry_out, aux_carry_out, overflow_out}, 32'd0);

    // Reset asserted during MUL step 4
    @(negedge clock);
    alu_opcode = OP_MUL; op_in_1 = 8'h80; op_in_2 = 8'h02; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_outs", {16'd0, op_out_1, op_out_2}, 32'd0);
    chk("arst_flags", {29'd0, carry_out, aux_carry_out, overflow_out}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    chk("arst_no_done", extra, 0);
    v = '{OP_ADD, 8'h0A, 8'h06, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    run_op(v, "post_rst_add");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
